store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/store_buffer.sv
// In-order store buffer with youngest-match load forwarding; stores are visible on the bus one cycle after acceptance.
// Head entry waits while bus_write_ready is low; a store arriving while full with no same-cycle drain is dropped and flagged.
module store_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            memory_write_enable,
    input  logic [XLEN-1:0] memory_address,
    input  logic [XLEN-1:0] memory_write_data,
    output logic [XLEN-1:0] memory_read_data,
    output logic            bus_write_valid,
    input  logic            bus_write_ready,
    output logic [XLEN-1:0] bus_write_address,
    output logic [XLEN-1:0] bus_write_data,
    output logic [XLEN-1:0] bus_read_address,
    input  logic [XLEN-1:0] bus_read_data,
    output logic            buffer_full,
    output logic            buffer_empty,
    output logic            overflow
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;
    logic            overflow_q;
    logic            enq;
    logic            deq;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic [PW-1:0]   idx;

    assign buffer_empty      = (count == '0);
    assign buffer_full       = (count == (PW+1)'(DEPTH));
    assign bus_write_valid   = !buffer_empty;
    assign bus_write_address = buffer_empty ? '0 : mem[head].addr;
    assign bus_write_data    = buffer_empty ? '0 : mem[head].data;
    assign bus_read_address  = memory_address;
    assign overflow          = overflow_q;

    assign deq = bus_write_valid && bus_write_ready;
    assign enq = memory_write_enable && (!buffer_full || deq);

    // Walk oldest to youngest so the last match wins; the incoming store is not yet in mem.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < count) && (mem[idx].addr == memory_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[idx].data;
            end
        end
    end

    assign memory_read_data = fwd_hit ? fwd_data : bus_read_data;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (memory_write_enable && !enq) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst && enq) begin
            mem[tail] <= '{addr: memory_address, data: memory_write_data};
        end
    end

endmodule
